gray_step_tracker: RTL and testbench



---
 rtl/gray_step_tracker_if.sv | 32 +++
 rtl/gray_step_tracker.sv | 153 +++++++++++++++
 tb/tb_gray_step_tracker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/gray_step_tracker_if.sv
// Bundles the Gray-code input, clear and all tracker outputs into one port.
// Latency: none; wires only.
// Backpressure: none; the tracker output is a free-running status/pulse stream.
interface gray_step_tracker_if #(
    parameter int POS_W = 8
);
    logic [2:0]       gray_in;
    logic             clear;
    logic [2:0]       bin_out;
    logic             step_valid;
    logic             step_dir;
    logic [POS_W-1:0] pos;
    logic             wrap_up;
    logic             wrap_down;
    logic             err;
    logic             err_sticky;
    logic             busy;

    // Stimulus side: drives the code and clear, observes tracker results.
    modport master (
        output gray_in, clear,
        input  bin_out, step_valid, step_dir, pos, wrap_up, wrap_down,
               err, err_sticky, busy
    );

    // Tracker side.
    modport slave (
        input  gray_in, clear,
        output bin_out, step_valid, step_dir, pos, wrap_up, wrap_down,
               err, err_sticky, busy
    );
endinterface

// File: rtl/gray_step_tracker.sv
// Synchronises a 3-bit Gray counter, decodes it, tracks single steps and position, flags jumps.
// Latency: gray_in stable before edge E0 shows on registered outputs at edge E0+SYNC_STAGES.
// Backpressure: none; every accepted step or error is reported as a one-cycle pulse.
module gray_step_tracker #(
    parameter int SYNC_STAGES = 2,
    parameter int POS_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    gray_step_tracker_if.slave bus
);

    typedef enum logic [1:0] {INIT, PRIME, TRACK} state_t;

    state_t                       state, state_nxt;
    logic [SYNC_STAGES-1:0][2:0]  sync_q;
    logic [2:0]                   g_s;
    logic [1:0]                   init_cnt, init_cnt_nxt;
    logic [2:0]                   g_prev, g_prev_nxt;
    logic [2:0]                   bin_q, bin_nxt;
    logic [POS_W-1:0]             pos_q, pos_nxt;
    logic                         sticky_q, sticky_nxt;
    logic                         step_q, step_nxt;
    logic                         dir_q, dir_nxt;
    logic                         wup_q, wup_nxt;
    logic                         wdn_q, wdn_nxt;
    logic                         err_q, err_nxt;
    logic                         busy_q;
    logic [2:0]                   d;
    logic [2:0]                   bin_new;
    logic                         one_bit;
    logic                         multi_bit;
    logic                         up;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    assign g_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous Gray input; stage 0 samples gray_in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.gray_in};
        end
    end

    // Next-state and next-output logic: INIT waits for the chain to fill, PRIME
    // adopts the current code without reporting, TRACK classifies each change.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        g_prev_nxt   = g_prev;
        bin_nxt      = bin_q;
        pos_nxt      = pos_q;
        sticky_nxt   = sticky_q;
        step_nxt     = 1'b0;
        dir_nxt      = 1'b0;
        wup_nxt      = 1'b0;
        wdn_nxt      = 1'b0;
        err_nxt      = 1'b0;

        d         = g_s ^ g_prev;
        multi_bit = (d & (d - 3'd1)) != 3'd0;
        one_bit   = (d != 3'd0) && !multi_bit;
        bin_new   = gray2bin(g_s);
        // bin_q always holds the decode of g_prev, so it serves as the old position.
        up        = (bin_new == bin_q + 3'd1);

        case (state)
            INIT: begin
                if (init_cnt == 2'(SYNC_STAGES - 1)) begin
                    state_nxt = PRIME;
                end else begin
                    init_cnt_nxt = init_cnt + 2'd1;
                end
            end
            PRIME: begin
                g_prev_nxt = g_s;
                bin_nxt    = bin_new;
                state_nxt  = TRACK;
            end
            TRACK: begin
                if (one_bit) begin
                    step_nxt   = 1'b1;
                    dir_nxt    = up;
                    g_prev_nxt = g_s;
                    bin_nxt    = bin_new;
                    pos_nxt    = up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    wup_nxt    = up && (bin_q == 3'd7);
                    wdn_nxt    = !up && (bin_q == 3'd0);
                end else if (multi_bit) begin
                    // Missed steps or a glitch: resynchronise without moving pos.
                    err_nxt    = 1'b1;
                    sticky_nxt = 1'b1;
                    g_prev_nxt = g_s;
                    bin_nxt    = bin_new;
                end
            end
            default: state_nxt = INIT;
        endcase

        // clear overrides the accumulator and sticky flag only; pulses still fire.
        if (bus.clear) begin
            pos_nxt    = '0;
            sticky_nxt = 1'b0;
        end
    end

    // State, tracking registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= 2'd0;
            g_prev   <= 3'd0;
            bin_q    <= 3'd0;
            pos_q    <= '0;
            sticky_q <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            wup_q    <= 1'b0;
            wdn_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            g_prev   <= g_prev_nxt;
            bin_q    <= bin_nxt;
            pos_q    <= pos_nxt;
            sticky_q <= sticky_nxt;
            step_q   <= step_nxt;
            dir_q    <= dir_nxt;
            wup_q    <= wup_nxt;
            wdn_q    <= wdn_nxt;
            err_q    <= err_nxt;
            busy_q   <= (state_nxt != TRACK);
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.step_valid = step_q;
    assign bus.step_dir   = dir_q;
    assign bus.pos        = pos_q;
    assign bus.wrap_up    = wup_q;
    assign bus.wrap_down  = wdn_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Bench for gray_step_tracker: directed scenarios plus random walks against a table-driven model.
// Latency: expects results two edges after each gray_in change (SYNC_STAGES=2).
// Backpressure: none; each code is held four cycles.
module tb_gray_step_tracker;

    localparam int POS_W = 8;
    localparam int POS_M = 1 << POS_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gray_step_tracker_if #(.POS_W(POS_W)) bus ();

    gray_step_tracker #(
        .SYNC_STAGES (2),
        .POS_W       (POS_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: position on the 8-entry Gray cycle, accumulator, sticky flag.
    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int m_bin;
    int m_pos;
    bit m_sticky;

    function automatic int bin_of(input logic [2:0] code);
        for (int i = 0; i < 8; i++) begin
            if (gray_tab[i] == int'(code)) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_step"}, 32'(bus.step_valid), 0);
        chk({tag, "_err"},  32'(bus.err), 0);
        chk({tag, "_wup"},  32'(bus.wrap_up), 0);
        chk({tag, "_wdn"},  32'(bus.wrap_down), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bin"},    32'(bus.bin_out), 0);
        chk({tag, "_pos"},    32'(bus.pos), 0);
        chk({tag, "_busy"},   32'(bus.busy), 1);
        chk({tag, "_sticky"}, 32'(bus.err_sticky), 0);
        chk({tag, "_dir"},    32'(bus.step_dir), 0);
        check_quiet(tag);
    endtask

    // Hold reset with a code on the input, release it, and watch INIT/PRIME.
    task automatic do_reset(input logic [2:0] code);
        reset       = 1'b0;
        bus.clear   = 1'b0;
        bus.gray_in = code;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk("busy", 32'(bus.busy), (k < 3) ? 1 : 0);
            chk("prime_pos", 32'(bus.pos), 0);
            check_quiet("prime");
        end
        chk("prime_bin", 32'(bus.bin_out), 32'(bin_of(code)));
        m_bin    = bin_of(code);
        m_pos    = 0;
        m_sticky = 1'b0;
    endtask

    // Drive one code for four cycles; optionally assert clear on the edge that
    // registers the result. Checks every cycle against the model.
    task automatic apply(input logic [2:0] code, input bit clr);
        int  ham, nb, new_pos, new_bin;
        bit  e_step, e_err, e_up, e_wu, e_wd, new_sticky;
        ham    = $countones(code ^ 3'(gray_tab[m_bin]));
        nb     = bin_of(code);
        e_step = (ham == 1);
        e_err  = (ham >= 2);
        e_up   = (nb == (m_bin + 1) % 8);
        e_wu   = e_step && e_up && (m_bin == 7);
        e_wd   = e_step && !e_up && (m_bin == 0);
        new_pos = m_pos;
        if (e_step) new_pos = (m_pos + (e_up ? 1 : -1) + POS_M) % POS_M;
        if (clr) new_pos = 0;
        new_sticky = clr ? 1'b0 : (m_sticky | e_err);
        new_bin    = (ham != 0) ? nb : m_bin;

        bus.gray_in = code;
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) bus.clear = clr;
            @(posedge clk);
            #1;
            bus.clear = 1'b0;
            if (k == 3) begin
                chk("step_valid", 32'(bus.step_valid), 32'(e_step));
                chk("err",        32'(bus.err), 32'(e_err));
                chk("wrap_up",    32'(bus.wrap_up), 32'(e_wu));
                chk("wrap_down",  32'(bus.wrap_down), 32'(e_wd));
                if (e_step) chk("step_dir", 32'(bus.step_dir), 32'(e_up));
                chk("bin_new",    32'(bus.bin_out), 32'(new_bin));
                chk("pos_new",    32'(bus.pos), 32'(new_pos));
                chk("sticky_new", 32'(bus.err_sticky), 32'(new_sticky));
            end else if (k < 3) begin
                check_quiet("early");
                chk("bin_old", 32'(bus.bin_out), 32'(m_bin));
                chk("pos_old", 32'(bus.pos), 32'(m_pos));
            end else begin
                check_quiet("late");
                chk("bin_hold", 32'(bus.bin_out), 32'(new_bin));
            end
        end
        m_bin    = new_bin;
        m_pos    = new_pos;
        m_sticky = new_sticky;
    endtask

    initial begin
        int          r, nb;
        bit          clr;
        logic [2:0]  seq [8];

        reset       = 1'b0;
        bus.gray_in = 3'b000;
        bus.clear   = 1'b0;
        @(posedge clk);
        #1;

        // Start-up from a non-zero code: PRIME adopts it silently.
        do_reset(3'b110);
        chk("prime_110_bin", 32'(bus.bin_out), 4);

        // Full up cycle with a single wrap_up at the end.
        do_reset(3'b000);
        seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        for (int i = 0; i < 8; i++) apply(seq[i], 1'b0);
        chk("upcycle_pos", 32'(bus.pos), 8);
        chk("upcycle_bin", 32'(bus.bin_out), 0);

        // Down steps through 0 -> 7 -> 6, position wraps below zero.
        do_reset(3'b000);
        apply(3'b100, 1'b0);
        apply(3'b101, 1'b0);
        chk("down_pos", 32'(bus.pos), 254);
        chk("down_bin", 32'(bus.bin_out), 6);

        // Two-bit jump reports err, then tracking resumes from the new code.
        do_reset(3'b000);
        apply(3'b011, 1'b0);
        chk("jump_sticky", 32'(bus.err_sticky), 1);
        chk("jump_bin", 32'(bus.bin_out), 2);
        apply(3'b010, 1'b0);
        chk("after_jump_bin", 32'(bus.bin_out), 3);
        chk("after_jump_pos", 32'(bus.pos), 1);

        // clear coincident with a step at pos=5, then with an err.
        do_reset(3'b000);
        for (int i = 0; i < 5; i++) apply(seq[i], 1'b0);
        chk("pre_clear_pos", 32'(bus.pos), 5);
        apply(3'b101, 1'b1);
        chk("clear_step_pos", 32'(bus.pos), 0);
        chk("clear_step_bin", 32'(bus.bin_out), 6);
        apply(3'b000, 1'b0);
        chk("err_sets_sticky", 32'(bus.err_sticky), 1);
        apply(3'b101, 1'b1);
        chk("clear_err_sticky", 32'(bus.err_sticky), 0);

        // Reset asserted mid-step clears outputs without waiting for an edge.
        apply(3'b100, 1'b0);
        bus.gray_in = 3'b000;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("async_rst");

        // Random walk: mostly single steps, some holds, jumps and clears.
        do_reset(3'b000);
        repeat (60) begin
            r = $urandom_range(0, 9);
            if (r < 4)      nb = (m_bin + 1) % 8;
            else if (r < 7) nb = (m_bin + 7) % 8;
            else if (r < 8) nb = m_bin;
            else            nb = $urandom_range(0, 7);
            clr = ($urandom_range(0, 9) == 0);
            apply(3'(gray_tab[nb]), clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
